pipeline_hazard_ctrl: RTL and testbench

- Control-side counterpart of the IF/ID pipeline register: generates the stall (hazard_IF_ID) and flush controls that register consumes, plus PC-write, ID/EX bubble and whole-pipe freeze.
- Combines combinational load-use and branch/jump detection with a small FSM that sequences multi-cycle data-memory freezes.
- Keeps saturating stall/flush event counters for performance debug.

---
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the IF/ID boundary: load-use stall, branch/jump flush,
// multi-cycle data-memory freeze sequencing and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             jump_i,
  input  logic             mem_access_i,
  output logic             pc_write_o,
  output logic             hazard_IF_ID_o,
  output logic             flush_IF_ID_o,
  output logic             bubble_ID_EX_o,
  output logic             freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } state_t;

  localparam bit             MULTI_CYCLE = (MEM_LATENCY > 1);
  localparam bit             LONG_ACCESS = (MEM_LATENCY > 2);
  localparam logic [1:0]     WAIT_INIT   = (MEM_LATENCY > 3) ? 2'(MEM_LATENCY - 3) : 2'd0;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [1:0]       wait_r;
  logic [1:0]       wait_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             load_use_s;
  logic             redirect_s;
  logic             mem_freeze_s;

  // Hazard classification from the current ID/EX contents
  always_comb begin
    load_use_s   = ex_memread_i & (ex_rt_i != 5'd0) &
                   ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
    redirect_s   = branch_taken_i | jump_i;
    mem_freeze_s = (state_r == MEM_WAIT) |
                   ((state_r == RUN) & mem_access_i & MULTI_CYCLE);
  end

  // Prioritised control outputs; a suppressed branch re-resolves once operands arrive
  always_comb begin
    pc_write_o     = 1'b1;
    hazard_IF_ID_o = 1'b0;
    flush_IF_ID_o  = 1'b0;
    bubble_ID_EX_o = 1'b0;
    freeze_o       = 1'b0;
    if (rst_i) begin
      pc_write_o = 1'b1;
    end else if (mem_freeze_s) begin
      freeze_o       = 1'b1;
      hazard_IF_ID_o = 1'b1;
      pc_write_o     = 1'b0;
    end else if (load_use_s) begin
      hazard_IF_ID_o = 1'b1;
      pc_write_o     = 1'b0;
      bubble_ID_EX_o = 1'b1;
    end else if (redirect_s) begin
      flush_IF_ID_o = 1'b1;
      pc_write_o    = 1'b1;
    end else begin
      pc_write_o = 1'b1;
    end
  end

  // Memory-freeze sequencer next state
  always_comb begin
    state_s = state_r;
    wait_s  = wait_r;
    case (state_r)
      RUN: begin
        if (mem_access_i && LONG_ACCESS) begin
          state_s = MEM_WAIT;
          wait_s  = WAIT_INIT;
        end else if (mem_access_i && MULTI_CYCLE) begin
          state_s = MEM_DONE;
        end else begin
          state_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (wait_r == 2'd0) begin
          state_s = MEM_DONE;
        end else begin
          wait_s = wait_r - 2'd1;
        end
      end
      MEM_DONE: begin
        state_s = RUN;
      end
      default: begin
        state_s = RUN;
        wait_s  = 2'd0;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= RUN;
      wait_r  <= 2'd0;
    end else begin
      state_r <= state_s;
      wait_r  <= wait_s;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (hazard_IF_ID_o && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end
      if (flush_IF_ID_o && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (latency 4/1/2) share stimulus and
// are checked against a countdown-based reference model, vector tables and corner sequences.
module tb_pipeline_hazard_ctrl;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, branch_taken, jump, mem_access;

  logic [2:0]  pc_w, hz_w, fl_w, bub_w, frz_w;
  logic [3:0]  sc0, fc0;
  logic [31:0] sc1, fc1;
  logic [7:0]  sc2, fc2;

  pipeline_hazard_ctrl #(.MEM_LATENCY(4), .CNT_W(4)) u_l4 (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(branch_taken), .jump_i(jump),
    .mem_access_i(mem_access), .pc_write_o(pc_w[0]), .hazard_IF_ID_o(hz_w[0]),
    .flush_IF_ID_o(fl_w[0]), .bubble_ID_EX_o(bub_w[0]), .freeze_o(frz_w[0]),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0));

  pipeline_hazard_ctrl #(.MEM_LATENCY(1), .CNT_W(32)) u_l1 (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(branch_taken), .jump_i(jump),
    .mem_access_i(mem_access), .pc_write_o(pc_w[1]), .hazard_IF_ID_o(hz_w[1]),
    .flush_IF_ID_o(fl_w[1]), .bubble_ID_EX_o(bub_w[1]), .freeze_o(frz_w[1]),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1));

  pipeline_hazard_ctrl #(.MEM_LATENCY(2), .CNT_W(8)) u_l2 (
    .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .branch_taken_i(branch_taken), .jump_i(jump),
    .mem_access_i(mem_access), .pc_write_o(pc_w[2]), .hazard_IF_ID_o(hz_w[2]),
    .flush_IF_ID_o(fl_w[2]), .bubble_ID_EX_o(bub_w[2]), .freeze_o(frz_w[2]),
    .stall_cnt_o(sc2), .flush_cnt_o(fc2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, idx, act, exp, $time);
    end
  endtask

  // Reference model: freeze tracked as remaining-cycles countdown plus a one-cycle grace.
  int     lat[N] = '{4, 1, 2};
  int     cw[N]  = '{4, 32, 8};
  int     busy[N];
  bit     done[N];
  longint scnt[N], fcnt[N];
  bit     m_pc[N], m_hz[N], m_fl[N], m_bub[N], m_frz[N];

  task automatic model_eval();
    bit lu, rd;
    lu = ex_memread && (ex_rt != 0) && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    rd = branch_taken || jump;
    for (int k = 0; k < N; k++) begin
      m_pc[k] = 1; m_hz[k] = 0; m_fl[k] = 0; m_bub[k] = 0; m_frz[k] = 0;
      if (!rst) begin
        m_frz[k] = (busy[k] > 0) || (!done[k] && mem_access && lat[k] > 1);
        if (m_frz[k]) begin
          m_pc[k] = 0; m_hz[k] = 1;
        end else if (lu) begin
          m_pc[k] = 0; m_hz[k] = 1; m_bub[k] = 1;
        end else if (rd) begin
          m_fl[k] = 1;
        end
      end
    end
  endtask

  task automatic model_update();
    longint cmax;
    for (int k = 0; k < N; k++) begin
      cmax = (longint'(1) << cw[k]) - 1;
      if (rst) begin
        busy[k] = 0; done[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end else begin
        if (m_hz[k] && scnt[k] < cmax) scnt[k]++;
        if (m_fl[k] && fcnt[k] < cmax) fcnt[k]++;
        if (busy[k] > 0) begin
          busy[k]--;
          if (busy[k] == 0) done[k] = 1;
        end else if (done[k]) begin
          done[k] = 0;
        end else if (mem_access && lat[k] > 1) begin
          busy[k] = lat[k] - 2;
          done[k] = (busy[k] == 0);
        end
      end
    end
  endtask

  task automatic sample();
    logic [63:0] asc[N], afc[N];
    @(negedge clk);
    model_eval();
    asc = '{64'(sc0), 64'(sc1), 64'(sc2)};
    afc = '{64'(fc0), 64'(fc1), 64'(fc2)};
    for (int k = 0; k < N; k++) begin
      cmp("pc_write", k, 64'(pc_w[k]), 64'(m_pc[k]));
      cmp("hazard_IF_ID", k, 64'(hz_w[k]), 64'(m_hz[k]));
      cmp("flush_IF_ID", k, 64'(fl_w[k]), 64'(m_fl[k]));
      cmp("bubble_ID_EX", k, 64'(bub_w[k]), 64'(m_bub[k]));
      cmp("freeze", k, 64'(frz_w[k]), 64'(m_frz[k]));
      cmp("stall_cnt", k, asc[k], 64'(scnt[k]));
      cmp("flush_cnt", k, afc[k], 64'(fcnt[k]));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic mr, input logic [4:0] ert, input logic br,
                        input logic jp, input logic acc, input logic r);
    id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_memread = mr; ex_rt = ert;
    branch_taken = br; jump = jp; mem_access = acc; rst = r;
  endtask

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses, mr;
    logic [4:0] ert;
    logic       br, jp;
    logic       pc, hz, fl, bub;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int exp_s, exp_f;
    for (int k = 0; k < N; k++) begin
      busy[k] = 0; done[k] = 0; scnt[k] = 0; fcnt[k] = 0;
    end
    //          rs     rt     use   mr    ert    br    jp    pc    hz    fl    bub
    vecs[0] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{5'd3, 5'd4, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{5'd2, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{5'd8, 5'd31, 1'b1, 1'b1, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;

    // Reset state: outputs forced, counters cleared
    sample();
    cmp("rst_pc_write", 0, 64'(pc_w), 64'(3'b111));
    cmp("rst_hazard", 0, 64'(hz_w | fl_w | bub_w | frz_w), 64'd0);
    advance();

    // Vector table on the single-cycle-memory instance
    exp_s = 0; exp_f = 0;
    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].uses, vecs[i].mr, vecs[i].ert,
             vecs[i].br, vecs[i].jp, 1'b0, 1'b0);
      sample();
      cmp("tbl_pc_write", i, 64'(pc_w[1]), 64'(vecs[i].pc));
      cmp("tbl_hazard", i, 64'(hz_w[1]), 64'(vecs[i].hz));
      cmp("tbl_flush", i, 64'(fl_w[1]), 64'(vecs[i].fl));
      cmp("tbl_bubble", i, 64'(bub_w[1]), 64'(vecs[i].bub));
      cmp("tbl_stall_cnt", i, 64'(sc1), 64'(exp_s));
      cmp("tbl_flush_cnt", i, 64'(fc1), 64'(exp_f));
      advance();
      exp_s += int'(vecs[i].hz);
      exp_f += int'(vecs[i].fl);
    end

    // Held memory access: latency-4 freezes 3 of every 4 cycles, latency-2 every other
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    sample(); advance();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      sample();
      cmp("hold_freeze_l4", i, 64'(frz_w[0]), 64'((i % 4) != 3));
      cmp("hold_freeze_l2", i, 64'(frz_w[2]), 64'((i % 2) == 0));
      cmp("hold_freeze_l1", i, 64'(frz_w[1]), 64'd0);
      advance();
    end

    // Reset in the second freeze cycle aborts the freeze
    sample();
    cmp("abort_first_freeze", 0, 64'(frz_w[0]), 64'd1);
    advance();
    rst = 1'b1;
    sample();
    cmp("abort_rst_freeze", 0, 64'(frz_w[0]), 64'd0);
    cmp("abort_rst_pc", 0, 64'(pc_w[0]), 64'd1);
    advance();
    rst = 1'b0; mem_access = 1'b0;
    sample();
    cmp("abort_after_freeze", 0, 64'(frz_w[0]), 64'd0);
    cmp("abort_after_stall_cnt", 0, 64'(sc0), 64'd0);
    advance();
    mem_access = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      cmp("refreeze_l4", i, 64'(frz_w[0]), 64'(i != 3));
      advance();
    end

    // Stall-counter saturation on the 4-bit instance
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    sample(); advance();
    set_in(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      sample(); advance();
    end
    sample();
    cmp("sat_stall_cnt_w4", 0, 64'(sc0), 64'd15);
    cmp("sat_stall_cnt_w8", 2, 64'(sc2), 64'd20);
    cmp("sat_stall_cnt_w32", 1, 64'(sc1), 64'd20);
    advance();

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 9) < 1),
             1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 49) == 0));
      sample(); advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
